muldiv_ctrl: RTL and testbench

//  Sequencer for the multi-cycle multiply/divide resource and owner of the HI/LO registers.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_if.sv | 22 ++
 rtl/div_radix2.sv | 56 +++++
 rtl/muldiv_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer: opcodes, FSM states, default latencies.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MUL_LAT_DEF   = 2;
  localparam int DIV_ITERS_DEF = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_RUN  = 2'd2,
    FINISH   = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_if.sv
// EX-stage to multiply/divide unit connection: request side and HI/LO/stall return side.
interface muldiv_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op, src_a, src_b, flush,
    input  stall, done, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    output stall, done, hi, lo
  );
endinterface

// File: rtl/div_radix2.sv
// Unsigned restoring divider, one quotient bit per cycle; quotient/remainder outputs show
// the result of the step being taken this cycle, so the final values appear with last_iter.
module div_radix2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         kill,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         last_iter
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     quo_p0;
  logic [W-1:0]     rem_p0;
  logic [W-1:0]     dvs_p0;
  logic [CNT_W-1:0] cnt;
  logic [W:0]       shifted;
  logic             ge;

  always_comb begin
    shifted   = {rem_p0, quo_p0[W-1]};
    ge        = (shifted >= {1'b0, dvs_p0});
    remainder = ge ? W'(shifted - {1'b0, dvs_p0}) : shifted[W-1:0];
    quotient  = {quo_p0[W-2:0], ge};
  end

  assign last_iter = (cnt == CNT_W'(1));

  // iteration stage: quotient bits shift in as dividend bits shift out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_p0 <= '0;
      rem_p0 <= '0;
      dvs_p0 <= '0;
      cnt    <= '0;
    end else if (kill) begin
      cnt <= '0;
    end else if (start) begin
      quo_p0 <= dividend;
      rem_p0 <= '0;
      dvs_p0 <= divisor;
      cnt    <= CNT_W'(W);
    end else if (cnt != '0) begin
      quo_p0 <= quotient;
      rem_p0 <= remainder;
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer beside the EX ALU: stalls the pipe during MULT/DIV, owns HI/LO,
// and abandons an in-flight operation on flush without touching HI/LO.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT   = MUL_LAT_DEF,
  parameter int DIV_ITERS = DIV_ITERS_DEF
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam int MCNT_W = $clog2(MUL_LAT + 1);

  state_t              state, state_nxt;
  logic                stall_c, issue_mul, issue_div, wr_hi, wr_lo;
  logic                mul_commit, div_commit;
  logic [MCNT_W-1:0]   mul_cnt;
  logic [31:0]         hi_r, lo_r;
  logic                q_neg, r_neg, is_div_s;
  logic [31:0]         a_mag, b_mag;
  logic signed [32:0]  mul_a_p0, mul_b_p0;
  logic                vld_p0;
  logic [63:0]         mul_full, mul_res;
  logic                mul_res_vld;
  logic [31:0]         div_quo, div_rem;
  logic                div_last;

  function automatic logic [31:0] sign_fix(input logic [31:0] mag, input logic neg);
    return neg ? (~mag + 32'd1) : mag;
  endfunction

  always_comb begin
    is_div_s = (bus.op == OP_DIV);
    a_mag    = sign_fix(bus.src_a, is_div_s & bus.src_a[31]);
    b_mag    = sign_fix(bus.src_b, is_div_s & bus.src_b[31]);
  end

  always_comb begin
    state_nxt  = state;
    stall_c    = 1'b0;
    issue_mul  = 1'b0;
    issue_div  = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    mul_commit = 1'b0;
    div_commit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.op_valid && !bus.flush) begin
          case (bus.op)
            OP_MTHI: wr_hi = 1'b1;
            OP_MTLO: wr_lo = 1'b1;
            OP_MULT, OP_MULTU: begin
              stall_c   = 1'b1;
              issue_mul = 1'b1;
              state_nxt = MUL_WAIT;
            end
            OP_DIV, OP_DIVU: begin
              stall_c = 1'b1;
              if (bus.src_b == '0) begin
                state_nxt = FINISH;
              end else begin
                issue_div = 1'b1;
                state_nxt = DIV_RUN;
              end
            end
            default: ;
          endcase
        end
      end
      MUL_WAIT: begin
        stall_c = 1'b1;
        if (bus.flush) begin
          state_nxt = IDLE;
        end else if (mul_cnt == MCNT_W'(1)) begin
          mul_commit = mul_res_vld;
          state_nxt  = FINISH;
        end
      end
      DIV_RUN: begin
        stall_c = 1'b1;
        if (bus.flush) begin
          state_nxt = IDLE;
        end else if (div_last) begin
          div_commit = 1'b1;
          state_nxt  = FINISH;
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand stage: latch multiplier inputs and divide sign flags at issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mul_cnt  <= '0;
      mul_a_p0 <= '0;
      mul_b_p0 <= '0;
      vld_p0   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p0 <= issue_mul;
      if (issue_mul) begin
        mul_cnt  <= MCNT_W'(MUL_LAT);
        mul_a_p0 <= {(bus.op == OP_MULT) & bus.src_a[31], bus.src_a};
        mul_b_p0 <= {(bus.op == OP_MULT) & bus.src_b[31], bus.src_b};
      end else if (state == MUL_WAIT) begin
        mul_cnt <= bus.flush ? '0 : mul_cnt - MCNT_W'(1);
      end
      if (issue_div) begin
        q_neg <= is_div_s & (bus.src_a[31] ^ bus.src_b[31]);
        r_neg <= is_div_s & bus.src_a[31];
      end
    end
  end

  assign mul_full = 64'(mul_a_p0) * 64'(mul_b_p0);

  if (MUL_LAT == 1) begin : g_mul_comb
    assign mul_res     = mul_full;
    assign mul_res_vld = vld_p0;
  end else begin : g_mul_pipe
    logic [63:0]        prod_p [MUL_LAT-1];
    logic [MUL_LAT-2:0] vld_p;

    // product stages: valid chain is dropped on flush so a cancelled multiply never commits
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_p <= '0;
        for (int i = 0; i < MUL_LAT - 1; i++) prod_p[i] <= '0;
      end else begin
        vld_p[0]  <= vld_p0 & ~bus.flush;
        prod_p[0] <= mul_full;
        for (int i = 1; i < MUL_LAT - 1; i++) begin
          vld_p[i]  <= vld_p[i-1] & ~bus.flush;
          prod_p[i] <= prod_p[i-1];
        end
      end
    end

    assign mul_res     = prod_p[MUL_LAT-2];
    assign mul_res_vld = vld_p[MUL_LAT-2];
  end

  div_radix2 #(.W(DIV_ITERS)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (issue_div),
    .kill      (bus.flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .last_iter (div_last)
  );

  // commit stage: HI/LO architectural state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (mul_commit) begin
      {hi_r, lo_r} <= mul_res;
    end else if (div_commit) begin
      lo_r <= sign_fix(div_quo, q_neg);
      hi_r <= sign_fix(div_rem, r_neg);
    end else if (wr_hi) begin
      hi_r <= bus.src_a;
    end else if (wr_lo) begin
      lo_r <= bus.src_a;
    end
  end

  assign bus.stall = stall_c;
  assign bus.done  = (state == FINISH);
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with MUL_LAT=2: latencies, signed/unsigned results,
// divide-by-zero, flush and asynchronous reset mid-operation.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  muldiv_if bus();

  muldiv_ctrl #(.MUL_LAT(2), .DIV_ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue at the cycle after the next edge, count stalled cycles, end at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall);
    int n;
    int early;
    n     = 0;
    early = 0;
    cyc();
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.src_a    = a;
    bus.src_b    = b;
    @(negedge clk);
    while (bus.stall === 1'b1 && n < 100) begin
      n++;
      if (bus.done === 1'b1) early++;
      cyc();
      bus.op_valid = 1'b0;
      @(negedge clk);
    end
    bus.op_valid = 1'b0;
    chk({tag, " stall_cycles"}, 64'(n), 64'(exp_stall));
    chk({tag, " early_done"}, 64'(early), 64'd0);
    chk({tag, " done"}, 64'(bus.done), 64'd1);
  endtask

  task automatic mov(input string tag, input logic [2:0] op, input logic [31:0] a, input logic fl);
    cyc();
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.src_a    = a;
    bus.flush    = fl;
    @(negedge clk);
    chk({tag, " stall"}, 64'(bus.stall), 64'd0);
    cyc();
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    chk({tag, " done"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst          = 1'b1;
    bus.op_valid = 1'b0;
    bus.op       = OP_MULT;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.flush    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset stall", 64'(bus.stall), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    cyc();
    rst = 1'b0;

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 3);
    chk("mult_neg hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    cyc();
    @(negedge clk);
    chk("mult_neg done_pulse", 64'(bus.done), 64'd0);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
    chk("multu_max hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    mov("mthi", OP_MTHI, 32'h0000_1234, 1'b0);
    chk("mthi hilo", {bus.hi, bus.lo}, 64'h0000_1234_0000_0001);

    run_op("mult_m1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
    chk("mult_m1 hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_0001);

    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 33);
    chk("div_neg hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 33);
    chk("divu_7_2 hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0003);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    chk("div_ovf hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    run_op("div_mix", OP_DIV, 32'd7, 32'hFFFF_FFFE, 33);
    chk("div_mix hilo", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFD);
    run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd10, 33);
    chk("divu_big hilo", {bus.hi, bus.lo}, 64'h0000_0005_1999_9999);
    run_op("div_m1_10", OP_DIV, 32'hFFFF_FFFF, 32'd10, 33);
    chk("div_m1_10 hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_0000_0000);

    mov("mthi_a", OP_MTHI, 32'h0000_AAAA, 1'b0);
    mov("mtlo_5", OP_MTLO, 32'h0000_5555, 1'b0);
    chk("mtx hilo", {bus.hi, bus.lo}, 64'h0000_AAAA_0000_5555);
    run_op("div_zero", OP_DIV, 32'h1234_5678, 32'd0, 1);
    chk("div_zero hilo", {bus.hi, bus.lo}, 64'h0000_AAAA_0000_5555);

    mov("mthi_flush", OP_MTHI, 32'h0000_DEAD, 1'b1);
    chk("mthi_flush hilo", {bus.hi, bus.lo}, 64'h0000_AAAA_0000_5555);
    cyc();
    bus.op_valid = 1'b1;
    bus.op       = OP_MULT;
    bus.src_a    = 32'd9;
    bus.src_b    = 32'd9;
    bus.flush    = 1'b1;
    @(negedge clk);
    chk("mult_flush stall_T", 64'(bus.stall), 64'd0);
    cyc();
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    chk("mult_flush stall_T1", 64'(bus.stall), 64'd0);
    repeat (3) cyc();
    @(negedge clk);
    chk("mult_flush hilo", {bus.hi, bus.lo}, 64'h0000_AAAA_0000_5555);

    cyc();
    bus.op_valid = 1'b1;
    bus.op       = OP_DIVU;
    bus.src_a    = 32'd100;
    bus.src_b    = 32'd7;
    @(negedge clk);
    chk("div_flush stall_T", 64'(bus.stall), 64'd1);
    cyc();
    bus.op_valid = 1'b0;
    repeat (9) cyc();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("div_flush stall_run10", 64'(bus.stall), 64'd1);
    cyc();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("div_flush stall_after", 64'(bus.stall), 64'd0);
    chk("div_flush done_after", 64'(bus.done), 64'd0);
    n = 0;
    repeat (40) begin
      cyc();
      @(negedge clk);
      if (bus.done === 1'b1 || bus.stall === 1'b1) n++;
    end
    chk("div_flush quiet", 64'(n), 64'd0);
    chk("div_flush hilo", {bus.hi, bus.lo}, 64'h0000_AAAA_0000_5555);
    run_op("mult_5x6", OP_MULT, 32'd5, 32'd6, 3);
    chk("mult_5x6 hilo", {bus.hi, bus.lo}, 64'd30);

    cyc();
    bus.op_valid = 1'b1;
    bus.op       = OP_DIVU;
    bus.src_a    = 32'd1000;
    bus.src_b    = 32'd3;
    cyc();
    bus.op_valid = 1'b0;
    repeat (5) cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst hilo", {bus.hi, bus.lo}, 64'd0);
    chk("async_rst stall", 64'(bus.stall), 64'd0);
    cyc();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("async_rst stall_rel", 64'(bus.stall), 64'd0);
    chk("async_rst done_rel", 64'(bus.done), 64'd0);
    run_op("mult_2x3", OP_MULT, 32'd2, 32'd3, 3);
    chk("mult_2x3 hilo", {bus.hi, bus.lo}, 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
